// File: rtl/io_write_buffer_if.sv
// CPU-side capture bus and UART-side byte stream of the IO write buffer.
interface io_write_buffer_if;
  logic        rdy_in;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output rdy_in, mem_a, mem_dout, mem_wr, tx_ready,
    input  io_buffer_full, tx_data, tx_valid
  );

  modport slave (
    input  rdy_in, mem_a, mem_dout, mem_wr, tx_ready,
    output io_buffer_full, tx_data, tx_valid
  );
endinterface

// File: rtl/io_write_buffer.sv
// Byte FIFO between CPU IO writes and a UART transmitter,
// with halt handling that flushes the queue then sends a 0x00 terminator.
module io_write_buffer #(
  parameter int DEPTH       = 16,
  parameter int FULL_MARGIN = 2
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  io_write_buffer_if.slave        bus,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    program_finished
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] FULL_TH = CW'(DEPTH - FULL_MARGIN);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_TERM  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    r_state;
  logic [1:0]    w_next;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic [7:0]    r_mem [DEPTH];

  logic w_sel;
  logic w_char_wr;
  logic w_halt_wr;
  logic w_run;
  logic w_drain;
  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push_req;
  logic w_push;
  logic w_drop;
  logic w_unused_addr;

  assign w_sel = bus.rdy_in & bus.mem_wr
               & (bus.mem_a[17:16] == 2'b11);
  assign w_char_wr = w_sel & (bus.mem_a[2:0] == 3'b000);
  assign w_halt_wr = w_sel & (bus.mem_a[2:0] == 3'b100);
  assign w_unused_addr = ^{bus.mem_a[31:18], bus.mem_a[15:3]};

  assign w_run   = (r_state == S_RUN);
  assign w_drain = w_run | (r_state == S_FLUSH);
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == DEPTH_C);

  // Drain runs off the UART side only, so rdy_in never stalls it.
  assign w_pop      = w_drain & ~w_empty & bus.tx_ready;
  assign w_push_req = w_char_wr & w_run & (bus.mem_dout != 8'h00);
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & w_full & ~w_pop;

  assign bus.tx_valid = w_drain ? ~w_empty : (r_state == S_TERM);
  assign bus.tx_data  = (w_drain & ~w_empty) ? r_mem[r_rd_ptr] : 8'h00;
  assign bus.io_buffer_full = (r_count >= FULL_TH);

  assign count            = r_count;
  assign overflow         = r_overflow;
  assign program_finished = (r_state == S_DONE);

  always_comb begin
    w_next = r_state;
    unique case (1'b1)
      (r_state == S_RUN):   if (w_halt_wr)    w_next = S_FLUSH;
      (r_state == S_FLUSH): if (w_empty)      w_next = S_TERM;
      (r_state == S_TERM):  if (bus.tx_ready) w_next = S_DONE;
      default:              w_next = r_state;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state    <= S_RUN;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_drop) r_overflow <= 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: tx_data is masked while the queue is empty.
  always_ff @(posedge clk_in) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.mem_dout;
  end

endmodule

// File: tb/tb_io_write_buffer.sv
// Directed and random stimulus for io_write_buffer,
// checked against a queue-based reference model.
module tb_io_write_buffer;

  localparam int DEPTH = 16;
  localparam int FM    = 2;

  typedef enum int {M_RUN, M_FLUSH, M_TERM, M_DONE} mst_t;

  logic       clk;
  logic       rst_in;
  logic [4:0] count;
  logic       overflow;
  logic       program_finished;

  io_write_buffer_if bus();

  io_write_buffer #(.DEPTH(DEPTH), .FULL_MARGIN(FM)) dut (
    .clk_in           (clk),
    .rst_in           (rst_in),
    .bus              (bus.slave),
    .count            (count),
    .overflow         (overflow),
    .program_finished (program_finished)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] q[$];
  mst_t       m_st;
  logic       m_ovf;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    q.delete();
    m_st  = M_RUN;
    m_ovf = 1'b0;
  endtask

  function automatic logic m_txv();
    if (m_st == M_RUN || m_st == M_FLUSH) return q.size() != 0;
    return m_st == M_TERM;
  endfunction

  function automatic logic [7:0] m_txd();
    if ((m_st == M_RUN || m_st == M_FLUSH) && q.size() != 0) return q[0];
    return 8'h00;
  endfunction

  task automatic check_all(string tag);
    chk({tag, ".count"}, 32'(count), 32'(q.size()));
    chk({tag, ".tx_valid"}, 32'(bus.tx_valid), 32'(m_txv()));
    chk({tag, ".tx_data"}, 32'(bus.tx_data), 32'(m_txd()));
    chk({tag, ".full"}, 32'(bus.io_buffer_full),
        32'(q.size() >= DEPTH - FM));
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".finished"}, 32'(program_finished), 32'(m_st == M_DONE));
  endtask

  // One clock: model consumes the inputs seen at the edge, then compare.
  task automatic step(string tag);
    logic sel, cw, hw, pop, preq;
    int   sz;
    sel  = bus.rdy_in && bus.mem_wr && bus.mem_a[17:16] == 2'b11;
    cw   = sel && bus.mem_a[2:0] == 3'b000;
    hw   = sel && bus.mem_a[2:0] == 3'b100;
    sz   = q.size();
    pop  = m_txv() && bus.tx_ready && (m_st == M_RUN || m_st == M_FLUSH);
    preq = cw && m_st == M_RUN && bus.mem_dout != 8'h00;
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (preq) begin
      if (sz < DEPTH || pop) q.push_back(bus.mem_dout);
      else m_ovf = 1'b1;
    end
    case (m_st)
      M_RUN:   if (hw) m_st = M_FLUSH;
      M_FLUSH: if (sz == 0) m_st = M_TERM;
      M_TERM:  if (bus.tx_ready) m_st = M_DONE;
      default: m_st = m_st;
    endcase
    #1;
    check_all(tag);
  endtask

  task automatic wr(string tag, logic [31:0] a, logic [7:0] d);
    bus.mem_a    = a;
    bus.mem_dout = d;
    bus.mem_wr   = 1'b1;
    step(tag);
    bus.mem_wr   = 1'b0;
  endtask

  task automatic do_reset(string tag);
    rst_in = 1'b0;
    #1;
    m_reset();
    check_all(tag);
    @(posedge clk);
    #1;
    rst_in = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout reached before end of test");
    $fatal(1, "timeout");
  end

  initial begin
    rst_in       = 1'b0;
    bus.rdy_in   = 1'b1;
    bus.mem_a    = 32'h0;
    bus.mem_dout = 8'h00;
    bus.mem_wr   = 1'b0;
    bus.tx_ready = 1'b0;
    m_reset();
    #2;
    do_reset("reset");

    // "Hi" with the UART always ready
    bus.tx_ready = 1'b1;
    wr("hi_h", 32'h0003_0000, 8'h48);
    chk("hi_first", 32'(bus.tx_data), 32'h48);
    wr("hi_i", 32'h0003_0000, 8'h69);
    chk("hi_second", 32'(bus.tx_data), 32'h69);
    step("hi_drain");
    chk("hi_empty", 32'(count), 32'd0);

    // full queue with concurrent push+pop across pointer wrap
    do_reset("rst_wrap");
    bus.tx_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) wr("fill", 32'h0003_0000, 8'(8'h10 + i));
    bus.tx_ready = 1'b1;
    for (int k = 0; k < 20; k++) wr("pp", 32'h0003_0000, 8'(8'h80 + k));
    chk("pp_count", 32'(count), 32'd16);
    chk("pp_ovf", 32'(overflow), 32'd0);
    repeat (DEPTH + 2) step("pp_drain");

    // full threshold and overflow
    do_reset("rst_full");
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 13; i++) wr("f13", 32'h0003_0000, 8'(8'h30 + i));
    chk("full_13", 32'(bus.io_buffer_full), 32'd0);
    wr("f14", 32'h0003_0000, 8'h3d);
    chk("full_14", 32'(bus.io_buffer_full), 32'd1);
    wr("f15", 32'h0003_0000, 8'h3e);
    wr("f16", 32'h0003_0000, 8'h3f);
    wr("f17", 32'h0003_0000, 8'h40);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd16);

    // zero byte ignored, rdy_in low blocks capture
    do_reset("rst_zero");
    wr("zero", 32'h0003_0000, 8'h00);
    chk("zero_count", 32'(count), 32'd0);
    chk("zero_ovf", 32'(overflow), 32'd0);
    bus.rdy_in = 1'b0;
    wr("nordy", 32'h0003_0000, 8'h55);
    chk("nordy_count", 32'(count), 32'd0);
    bus.rdy_in = 1'b1;

    // halt: flush 3 bytes, terminator, done
    bus.tx_ready = 1'b0;
    wr("q1", 32'h0003_0000, 8'h61);
    wr("q2", 32'h0003_0000, 8'h62);
    wr("q3", 32'h0003_0000, 8'h63);
    wr("halt", 32'h0003_0004, 8'h00);
    wr("late1", 32'h0003_0000, 8'h64);
    wr("late2", 32'h0003_0000, 8'h65);
    chk("late_count", 32'(count), 32'd3);
    bus.rdy_in   = 1'b0;
    bus.tx_ready = 1'b1;
    repeat (3) step("flush");
    bus.tx_ready = 1'b0;
    step("to_term");
    chk("term_valid", 32'(bus.tx_valid), 32'd1);
    chk("term_data", 32'(bus.tx_data), 32'd0);
    bus.tx_ready = 1'b1;
    step("to_done");
    chk("done", 32'(program_finished), 32'd1);
    step("hold_done");
    bus.rdy_in = 1'b1;

    // async reset in the middle of a flush
    do_reset("rst_fl");
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) wr("f5", 32'h0003_0000, 8'(8'ha0 + i));
    wr("halt5", 32'h0003_0004, 8'h00);
    step("in_flush");
    #2;
    rst_in = 1'b0;
    #1;
    m_reset();
    chk("async_count", 32'(count), 32'd0);
    check_all("async");
    @(posedge clk);
    #1;
    rst_in = 1'b1;
    wr("post_rst", 32'h0003_0000, 8'h77);
    chk("post_rst_data", 32'(bus.tx_data), 32'h77);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] a;
      int          r;
      if (c % 400 == 399) do_reset("rst_rand");
      a = $urandom;
      r = $urandom_range(0, 63);
      if (r < 40)      a[17:0] = 18'h3_0000 | 18'(a[15:3]) << 3;
      else if (r < 41) a[17:0] = 18'h3_0004;
      else if (r < 50) a[17:16] = 2'b10;
      else if (r < 55) a[17:0] = 18'h3_0001;
      a[15:3] = a[15:3];
      bus.mem_a    = a;
      bus.mem_dout = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      bus.mem_wr   = 1'($urandom_range(0, 1));
      bus.rdy_in   = ($urandom_range(0, 7) != 0);
      bus.tx_ready = ($urandom_range(0, 2) == 0);
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
